// File: rtl/shifter_pkg.sv
// Shared encodings and step-size helper for the multicycle shift unit.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic int unsigned minStep(input int unsigned rem, input int unsigned maxStep);
    return (rem < maxStep) ? rem : maxStep;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift pass of 0..MAX_STEP positions.
// MULTICYCLE_SHIFTER_ROTATE_EN enables rotate-left for OP_ROL; otherwise OP_ROL shifts as SLL.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned STEP_WIDTH  = 5
) (
  input  logic [WORD_LENGTH-1:0] word,
  input  op_t                    op,
  input  logic [STEP_WIDTH-1:0]  step,
  output logic [WORD_LENGTH-1:0] result
);

  always_comb begin
    result = word << step;
    case (op)
      OP_SRL: result = word >> step;
      // Sign bit is never disturbed by >>>, so it stays equal to the original MSB.
      OP_SRA: result = $signed(word) >>> step;
`ifdef MULTICYCLE_SHIFTER_ROTATE_EN
      OP_ROL: result = (word << step) | (word >> (WORD_LENGTH - int'(step)));
`endif
      default: result = word << step;
    endcase
  end

endmodule

// File: rtl/multicycle_shifter.sv
// Iterative shifter: up to MAX_STEP positions per clock, start/done handshake.
// Optional rotate-left for op=11 under MULTICYCLE_SHIFTER_ROTATE_EN.
module multicycle_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned MAX_STEP    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [1:0]                     op,
  input  logic [$clog2(WORD_LENGTH)-1:0] shamt,
  input  logic [WORD_LENGTH-1:0]         data_in,
  output logic                           busy,
  output logic                           done,
  output logic [WORD_LENGTH-1:0]         data_out
);

  localparam int unsigned SHAMT_WIDTH = $clog2(WORD_LENGTH);

  state_t                 state, stateNext;
  op_t                    opReg;
  logic [WORD_LENGTH-1:0] work;
  logic [WORD_LENGTH-1:0] stepped;
  logic [SHAMT_WIDTH-1:0] rem;
  logic [SHAMT_WIDTH-1:0] stepAmt;
  logic                   load;
  logic                   lastStep;

  assign stepAmt  = SHAMT_WIDTH'(minStep(int'(rem), MAX_STEP));
  assign lastStep = (rem == stepAmt);

  shift_step #(
    .WORD_LENGTH (WORD_LENGTH),
    .STEP_WIDTH  (SHAMT_WIDTH)
  ) uStep (
    .word   (work),
    .op     (opReg),
    .step   (stepAmt),
    .result (stepped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        stateNext = ST_IDLE;
        if (start) begin
          load      = 1'b1;
          stateNext = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: if (lastStep) stateNext = ST_DONE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg    <= OP_SLL;
      work     <= '0;
      rem      <= '0;
      data_out <= '0;
    end else if (load) begin
      opReg <= op_t'(op);
      work  <= data_in;
      rem   <= shamt;
      if (shamt == '0) data_out <= data_in;
    end else if (state == ST_SHIFT) begin
      work <= stepped;
      rem  <= rem - stepAmt;
      if (lastStep) data_out <= stepped;
    end
  end

endmodule

// File: doc/multicycle_shifter.md
Name: multicycle_shifter

Overview:
- Parametrised iterative shift unit for the multicycle MIPS datapath; generalises the fixed left-shift-by-2 path.
- Supports logical left, logical right and arithmetic right shifts by a variable amount.
- Shifts at most MAX_STEP bit positions per clock, then reports the result with a start/done handshake.
- Serves SLL/SRL/SRA/SLLV/SRLV/SRAV in the execute state of the control FSM.

Parameters:
- WORD_LENGTH, 32, data width; must be a power of two, >= 8.
- MAX_STEP, 4, maximum bit positions shifted per cycle; 1..WORD_LENGTH.
- SHAMT_WIDTH, $clog2(WORD_LENGTH), derived localparam for the shift-amount width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when the unit is idle or in DONE.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see Optional Feature).
- shamt  in  SHAMT_WIDTH  shift amount, 0..WORD_LENGTH-1.
- data_in  in  WORD_LENGTH  operand.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when data_out becomes valid.
- data_out  out  WORD_LENGTH  result; held stable until the next accepted start.

Behaviour:
- Clock and reset: single clock domain (clk). Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, data_out=0, remaining count=0, latched op=SLL.
- Reset mid-operation aborts immediately. No done pulse is produced, and data_out is forced to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Latch op; load the working register from data_in; load rem=shamt.
  - If shamt==0, go to DONE (data_out=data_in). Otherwise go to SHIFT.
- SHIFT, each edge:
  - step = min(rem, MAX_STEP).
  - Apply step to the working register: SLL zero-fills at the LSB; SRL zero-fills at the MSB; SRA fills with the original bit[WORD_LENGTH-1].
  - rem -= step. When rem becomes 0, go to DONE.
  - start is ignored in SHIFT; it is not queued.
- DONE:
  - done=1 for exactly this cycle; data_out holds the result.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation with no idle bubble.
  - Otherwise go to IDLE.
- busy=1 in SHIFT and DONE; busy=0 in IDLE.
- Latency from the start-sampling edge to done high: 1 + ceil(shamt/MAX_STEP) edges. Examples: shamt=0 -> 1; shamt=31 with MAX_STEP=4 -> 9.
- data_out is registered; it updates only on the transition into DONE.
- op, shamt and data_in are don't-care except on the start-sampling edge.

Optional Feature:
- Macro: MULTICYCLE_SHIFTER_ROTATE_EN.
- Defined: op=11 performs rotate-left by shamt, with bits leaving the MSB re-entering at the LSB each step. Latency rule is unchanged.
- Undefined: op=11 is decoded as SLL, and no rotate logic is synthesised.

Decomposition:
- Package shifter_pkg holds:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROL;
  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE;
  - a function that computes min(rem, MAX_STEP).
- One natural combinational sub-module, shift_step: takes the working word, op and step (0..MAX_STEP) and returns the shifted word. The top level holds the FSM, counter and registers.

Test Plan:
- SLL, data_in=0x00000001, shamt=2 -> done 2 edges after start; data_out=0x00000004; busy high for 2 cycles.
- SRA, data_in=0x80000000, shamt=31 -> done after 9 edges; data_out=0xFFFFFFFF. Repeat as SRL -> 0x00000001.
- shamt=0, op=SRL, data_in=0xDEADBEEF -> done after 1 edge; data_out=0xDEADBEEF.
- start pulsed again during SHIFT with a different operand -> ignored; result equals the first operation. start held in the DONE cycle -> second operation begins with no IDLE cycle between.
- reset asserted asynchronously mid-SHIFT (SLL 0x0000FFFF by 20) -> busy, done and data_out go to 0 immediately; no done pulse follows. A new start after reset release gives a correct result.
- With MULTICYCLE_SHIFTER_ROTATE_EN: op=11, data_in=0x80000001, shamt=4 -> 0x00000018. Without the macro: same stimulus -> 0x00000010 (SLL).
